ddr3_cmd_arbiter: RTL and testbench

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

---
 rtl/ddr3_cmd_arbiter_pkg.sv | 14 +
 rtl/ddr3_cmd_arbiter.sv | 124 ++++++++++++
 tb/tb_ddr3_cmd_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared encodings for the DDR3 command arbiter: FSM states and grant direction.
package ddr3_cmd_arbiter_pkg;

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_WSEQ = 1'b1
    } state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

endpackage

// File: rtl/ddr3_cmd_arbiter.sv
// DDR3 command arbiter: merges write and read request ports into one registered
// command stream. Same-direction streaks are capped at STREAK_MAX while the
// other side waits; a write sequence (wr_lst_i=0) locks out reads until its
// last beat is accepted.
module ddr3_cmd_arbiter
    import ddr3_cmd_arbiter_pkg::*;
#(
    parameter int unsigned ADDRS        = 32,
    parameter int unsigned MEM_ID_WIDTH = 4,
    parameter int unsigned STREAK_MAX   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_req_i,
    output logic                    wr_ack_o,
    input  logic                    wr_lst_i,
    input  logic [MEM_ID_WIDTH-1:0] wr_tid_i,
    input  logic [ADDRS-1:0]        wr_adr_i,
    input  logic                    rd_req_i,
    output logic                    rd_ack_o,
    input  logic [MEM_ID_WIDTH-1:0] rd_tid_i,
    input  logic [ADDRS-1:0]        rd_adr_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic                    cmd_write_o,
    output logic [MEM_ID_WIDTH-1:0] cmd_tid_o,
    output logic [ADDRS-1:0]        cmd_adr_o
);

    localparam int unsigned CW = $clog2(STREAK_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    dir_t            dir;
    dir_t            acc_dir;
    logic [CW-1:0]   cnt;
    logic            grant_wr;
    logic            grant_rd;
    logic            slot_free;
    logic            wr_acc;
    logic            rd_acc;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_OPEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, handshake acks and next-state logic
    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        state_nxt = state;
        slot_free = ~cmd_valid_o | cmd_ready_i;

        case (state)
            ST_WSEQ: begin
                grant_wr = wr_req_i;
            end
            default: begin
                if (wr_req_i && rd_req_i) begin
                    if (cnt < CW'(STREAK_MAX)) begin
                        grant_wr = (dir == DIR_WR);
                        grant_rd = (dir == DIR_RD);
                    end else begin
                        grant_wr = (dir == DIR_RD);
                        grant_rd = (dir == DIR_WR);
                    end
                end else begin
                    grant_wr = wr_req_i;
                    grant_rd = rd_req_i;
                end
            end
        endcase

        wr_acc   = grant_wr & slot_free & reset;
        rd_acc   = grant_rd & slot_free & reset;
        wr_ack_o = wr_acc;
        rd_ack_o = rd_acc;
        acc_dir  = wr_acc ? DIR_WR : DIR_RD;

        if (wr_acc) begin
            state_nxt = wr_lst_i ? ST_OPEN : ST_WSEQ;
        end
    end

    // Streak tracking: only an accepted request moves dir/cnt
    always_ff @(posedge clock) begin
        if (!reset) begin
            dir <= DIR_RD;
            cnt <= '0;
        end else if (wr_acc || rd_acc) begin
            if (acc_dir == dir) begin
                if (cnt < CW'(STREAK_MAX)) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                dir <= acc_dir;
                cnt <= CW'(1);
            end
        end
    end

    // Command register: load on accept, hold under backpressure, clear valid on drain
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmd_valid_o <= 1'b0;
            cmd_write_o <= 1'b0;
            cmd_tid_o   <= '0;
            cmd_adr_o   <= '0;
        end else if (wr_acc || rd_acc) begin
            cmd_valid_o <= 1'b1;
            cmd_write_o <= wr_acc;
            cmd_tid_o   <= wr_acc ? wr_tid_i : rd_tid_i;
            cmd_adr_o   <= wr_acc ? wr_adr_i : rd_adr_i;
        end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Self-checking bench for ddr3_cmd_arbiter: a per-cycle behavioural model of
// the arbitration rules, plus directed scenarios with literal expectations.
module tb_ddr3_cmd_arbiter;

    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int SMAX = 4;

    logic          clock;
    logic          reset;
    logic          wr_req_i, wr_ack_o, wr_lst_i;
    logic [IW-1:0] wr_tid_i;
    logic [AW-1:0] wr_adr_i;
    logic          rd_req_i, rd_ack_o;
    logic [IW-1:0] rd_tid_i;
    logic [AW-1:0] rd_adr_i;
    logic          cmd_valid_o, cmd_ready_i, cmd_write_o;
    logic [IW-1:0] cmd_tid_o;
    logic [AW-1:0] cmd_adr_o;

    int checks = 0;
    int errors = 0;

    ddr3_cmd_arbiter #(.ADDRS(AW), .MEM_ID_WIDTH(IW), .STREAK_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .wr_req_i(wr_req_i), .wr_ack_o(wr_ack_o), .wr_lst_i(wr_lst_i),
        .wr_tid_i(wr_tid_i), .wr_adr_i(wr_adr_i),
        .rd_req_i(rd_req_i), .rd_ack_o(rd_ack_o),
        .rd_tid_i(rd_tid_i), .rd_adr_i(rd_adr_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_write_o(cmd_write_o), .cmd_tid_o(cmd_tid_o), .cmd_adr_o(cmd_adr_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_seq: inside a write sequence; m_dir: 0 read / 1 write; m_cnt: streak length
    bit            m_seq = 0;
    int            m_dir = 0;
    int            m_cnt = 0;
    bit            m_v = 0, m_w = 0;
    logic [IW-1:0] m_tid = '0;
    logic [AW-1:0] m_adr = '0;
    int            log_q[$];   // drained commands: write*256 + tid

    always @(negedge clock) begin : compare
        bit both, ew, er, free;
        int side;
        chk("cmd_valid", cmd_valid_o, m_v);
        chk("cmd_write", cmd_write_o, m_w);
        chk("cmd_tid",   cmd_tid_o,   m_tid);
        chk("cmd_adr",   cmd_adr_o,   m_adr);

        free = !m_v || cmd_ready_i;
        ew = 0; er = 0;
        if (reset && free) begin
            both = wr_req_i && rd_req_i;
            if (m_seq)       ew = wr_req_i;
            else if (both) begin
                side = (m_cnt < SMAX) ? m_dir : 1 - m_dir;
                ew = (side == 1);
                er = (side == 0);
            end else begin
                ew = wr_req_i;
                er = rd_req_i;
            end
        end
        chk("wr_ack", wr_ack_o, ew);
        chk("rd_ack", rd_ack_o, er);

        if (reset && cmd_valid_o && cmd_ready_i)
            log_q.push_back(cmd_write_o * 256 + int'(cmd_tid_o));

        if (!reset) begin
            m_seq = 0; m_dir = 0; m_cnt = 0;
            m_v = 0; m_w = 0; m_tid = '0; m_adr = '0;
        end else if (ew || er) begin
            side = ew ? 1 : 0;
            if (side == m_dir) m_cnt = (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
            else begin m_dir = side; m_cnt = 1; end
            if (ew) m_seq = !wr_lst_i;
            m_v = 1; m_w = ew;
            m_tid = ew ? wr_tid_i : rd_tid_i;
            m_adr = ew ? wr_adr_i : rd_adr_i;
        end else if (cmd_ready_i) begin
            m_v = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic idle_inputs();
        wr_req_i = 0; rd_req_i = 0; wr_lst_i = 1;
        wr_tid_i = '0; rd_tid_i = '0; wr_adr_i = '0; rd_adr_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        cmd_ready_i = 1;
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        log_q.delete();
    endtask

    // Hold a write request until acked; reads must never be acked meanwhile
    task automatic wr_until_ack(input logic [IW-1:0] tid, input logic lst, input logic rdreq);
        bit acked = 0;
        wr_req_i = 1; wr_tid_i = tid; wr_lst_i = lst; wr_adr_i = AW'(tid) << 4;
        rd_req_i = rdreq; rd_tid_i = 4'd6; rd_adr_i = 32'h600;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clock);
            chk("wseq_rd_ack_low", rd_ack_o, 0);
            if (wr_ack_o) acked = 1;
            tick();
        end
        if (!acked) chk("wr_ack_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit got;
        int exp_rr[12];
        reset = 0;
        cmd_ready_i = 1;
        idle_inputs();

        // Reset state
        tick();
        @(negedge clock);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_tid", cmd_tid_o, 0);
        chk("rst_adr", cmd_adr_o, 0);
        do_reset();

        // Streaks: both sides requesting, STREAK_MAX=4 -> R x4, W x4, R x4
        wr_req_i = 1; rd_req_i = 1; wr_lst_i = 1;
        for (int i = 0; i < 12; i++) begin
            wr_tid_i = IW'(i); rd_tid_i = IW'(i);
            tick();
        end
        idle_inputs();
        tick(); tick();
        exp_rr = '{0,0,0,0,1,1,1,1,0,0,0,0};
        chk("streak_count", log_q.size(), 12);
        for (int i = 0; i < 12 && i < log_q.size(); i++)
            chk($sformatf("streak_dir_%0d", i), log_q[i] / 256, exp_rr[i]);

        // Write sequence locks out the read
        do_reset();
        wr_until_ack(4'd3, 1'b0, 1'b0);
        wr_until_ack(4'd4, 1'b0, 1'b1);
        wr_until_ack(4'd5, 1'b1, 1'b1);
        wr_req_i = 0; rd_req_i = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (rd_ack_o) got = 1;
            tick();
        end
        chk("wseq_read_after", got, 1);
        idle_inputs();
        tick(); tick();
        chk("wseq_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("wseq_0", log_q[0], 256 + 3);
            chk("wseq_1", log_q[1], 256 + 4);
            chk("wseq_2", log_q[2], 256 + 5);
            chk("wseq_3", log_q[3], 6);
        end

        // Backpressure hold for 5 cycles
        do_reset();
        cmd_ready_i = 0;
        rd_req_i = 1; rd_tid_i = 4'd7; rd_adr_i = 32'h1000;
        @(negedge clock);
        chk("hold_rd_ack", rd_ack_o, 1);
        tick();
        rd_req_i = 0;
        wr_req_i = 1; wr_tid_i = 4'd2; wr_lst_i = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_valid", cmd_valid_o, 1);
            chk("hold_write", cmd_write_o, 0);
            chk("hold_tid", cmd_tid_o, 7);
            chk("hold_adr", cmd_adr_o, 32'h1000);
            chk("hold_wr_ack", wr_ack_o, 0);
            tick();
        end
        wr_req_i = 0; cmd_ready_i = 1;
        @(negedge clock);
        chk("hold_valid_at_ready", cmd_valid_o, 1);
        tick();
        @(negedge clock);
        chk("hold_valid_drop", cmd_valid_o, 0);

        // Back-to-back writes, no bubble
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_req_i = 1; wr_lst_i = 1; wr_tid_i = IW'(i); wr_adr_i = AW'(i * 4);
            @(negedge clock);
            chk("b2b_ack", wr_ack_o, 1);
            if (i > 0) chk("b2b_valid", cmd_valid_o, 1);
            tick();
        end
        idle_inputs();
        tick(); tick();
        chk("b2b_count", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk("b2b_tid", log_q[i], 256 + i);

        // Reset during a write sequence with a held command
        do_reset();
        cmd_ready_i = 0;
        wr_req_i = 1; wr_tid_i = 4'd9; wr_lst_i = 0; wr_adr_i = 32'h90;
        tick();
        wr_req_i = 0;
        tick();
        reset = 0; wr_req_i = 1; rd_req_i = 1; rd_tid_i = 4'd1; rd_adr_i = 32'h10;
        @(negedge clock);
        chk("rst_mid_wr_ack", wr_ack_o, 0);
        chk("rst_mid_rd_ack", rd_ack_o, 0);
        tick();
        reset = 1; wr_req_i = 0; cmd_ready_i = 1;
        @(negedge clock);
        chk("rst_mid_valid", cmd_valid_o, 0);
        chk("rst_mid_write", cmd_write_o, 0);
        chk("rst_mid_tid", cmd_tid_o, 0);
        chk("rst_mid_adr", cmd_adr_o, 0);
        chk("rst_mid_lone_rd", rd_ack_o, 1);
        tick();
        rd_req_i = 0;
        @(negedge clock);
        chk("rst_mid_rd_cmd", {cmd_valid_o, cmd_write_o}, 2'b10);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 99) != 0);
            wr_req_i    = ($urandom_range(0, 3) != 0);
            rd_req_i    = ($urandom_range(0, 3) != 0);
            wr_lst_i    = ($urandom_range(0, 2) != 0);
            cmd_ready_i = ($urandom_range(0, 3) != 0);
            wr_tid_i    = IW'($urandom);
            rd_tid_i    = IW'($urandom);
            wr_adr_i    = $urandom;
            rd_adr_i    = $urandom;
            tick();
        end
        idle_inputs();
        reset = 1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
